// File: rtl/serial_sub_pkg.sv
// Shared types and the full-subtractor borrow equation for the bit-serial subtractor.
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } sub_state_t;

  // Borrow out of a 1-bit a_i - b_i - bin.
  function automatic logic full_sub_borrow(input logic a_i, input logic b_i, input logic bin);
    return (~a_i & b_i) | (~(a_i ^ b_i) & bin);
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Start/result bundle of serial_sub_ctrl; overflow exists only with SERIAL_SUB_OVF_EN.
interface serial_sub_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             overflow;
`endif

  modport master (
    output start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    input  overflow,
`endif
    input  ready, busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    output overflow,
`endif
    output ready, busy, done, diff, borrow_out
  );

endinterface

// File: rtl/serial_sub_ctrl_full_sub_bit.sv
// Single combinational full-subtractor cell, reused every cycle by serial_sub_ctrl.
module full_sub_bit
  import serial_sub_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a_i ^ b_i ^ bin;
  assign bout = full_sub_borrow(a_i, b_i, bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a-b controller: one subtractor cell stepped LSB-first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  serial_sub_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_t       state, state_next;
  logic [WIDTH-1:0] sa, sb, sr;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt;
  logic             br, borrow_q;
  logic             cell_d, cell_bout;
  logic             accept, last;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == SHIFT) && (cnt == CNT_LAST);

  full_sub_bit u_cell (
    .a_i  (sa[0]),
    .b_i  (sb[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: these are plain registers, not a memory array, so all of them take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      sa  <= bus.a;
      sb  <= bus.b;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= {cell_d, sr[WIDTH-1:1]};
      br  <= cell_bout;
      cnt <= cnt + CNT_W'(1);
      // The final shift lands directly in diff; sr itself is only complete one edge later.
      if (last) begin
        diff_q   <= {cell_d, sr[WIDTH-1:1]};
        borrow_q <= cell_bout;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb, ovf_q;

  // Last cell output is the result MSB, so overflow is formed on the same edge as diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= bus.a[WIDTH-1];
        b_msb <= bus.b[WIDTH-1];
      end
      if (last) ovf_q <= (a_msb != b_msb) && (cell_d != a_msb);
    end
  end

  assign bus.overflow = ovf_q;
`endif

  assign bus.ready      = (state == IDLE);
  assign bus.busy       = (state == SHIFT) || (state == DONE);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: driver pushes arithmetic expectations, monitor checks on done.
`timescale 1ns/1ps
module tb_serial_sub_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];

  serial_sub_if #(.WIDTH(W)) bus ();

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned and signed arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t   e;
    longint sa, sb, r;
    e.diff   = W'((longint'(a) - longint'(b)) & ((64'd1 << W) - 1));
    e.borrow = (a < b);
    sa = a[W-1] ? longint'(a) - (64'sd1 <<< W) : longint'(a);
    sb = b[W-1] ? longint'(b) - (64'sd1 <<< W) : longint'(b);
    r  = sa - sb;
    e.ovf = (r > (64'sd1 <<< (W - 1)) - 1) || (r < -(64'sd1 <<< (W - 1)));
    e.acc = acc;
    return e;
  endfunction

  // Drive start for one cycle from a negedge; the op is expected only if the DUT is ready.
  task automatic poke(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    if (bus.ready) q.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_ready();
    poke(a, b);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Monitor: compares each done against the oldest expectation.
  initial begin
    logic prev_done = 1'b0;
    logic want_ready = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done  = 1'b0;
        want_ready = 1'b0;
      end else begin
        if (want_ready) check("ready_after_done", 64'(bus.ready), 64'd1);
        want_ready = 1'b0;
        check("ready_busy_excl", 64'(bus.ready ^ bus.busy), 64'd1);
        if (bus.done) begin
          check("done_not_consecutive", 64'(prev_done), 64'd0);
          check("done_busy", 64'(bus.busy), 64'd1);
          if (q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check("diff", 64'(bus.diff), 64'(e.diff));
            check("borrow_out", 64'(bus.borrow_out), 64'(e.borrow));
            check("latency", 64'(cyc - e.acc), 64'(W));
`ifdef SERIAL_SUB_OVF_EN
            check("overflow", 64'(bus.overflow), 64'(e.ovf));
`endif
          end
          want_ready = 1'b1;
        end
        prev_done = bus.done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #3;
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_diff", 64'(bus.diff), 64'd0);
    check("rst_borrow", 64'(bus.borrow_out), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    issue(8'h35, 8'h12);
    issue(8'h12, 8'h35);
    issue(8'h00, 8'h01);
    issue(8'hA5, 8'hA5);
    issue(8'h80, 8'h01);
    issue(8'h05, 8'h03);
    issue(8'h7F, 8'hFF);
    drain();

    // Start while busy must be ignored; a/b wiggle after acceptance too.
    issue(8'h50, 8'h10);
    repeat (2) @(negedge clk);
    poke(8'hFF, 8'h00);
    drain();
    check("hold_diff_40", 64'(bus.diff), 64'h40);

    // Async reset in the middle of an operation discards it and clears outputs.
    issue(8'h3C, 8'h11);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    check("mid_rst_ready", 64'(bus.ready), 64'd1);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_diff", 64'(bus.diff), 64'd0);
    check("mid_rst_borrow", 64'(bus.borrow_out), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // start held high: back-to-back operations, each accepted on an IDLE edge.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h09;
    bus.b = 8'h03;
    repeat (45) begin
      if (bus.ready) q.push_back(model(8'h09, 8'h03, cyc + 1));
      @(negedge clk);
    end
    bus.start = 1'b0;
    drain();

    // Randomised operands, gaps and ignored starts while busy.
    repeat (30) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 5) == 0) ra = '0;
      if ($urandom_range(0, 5) == 0) rb = '1;
      issue(ra, rb);
      if ($urandom_range(0, 2) == 0) poke(W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
